// File: rtl/score_tracker.sv
// Running rhythm-game statistics (combo, base/bonus score, accuracy, grade) fed one judged note per handshake.
// Optional SCORE_TRACKER_MAX_COMBO_EN adds a max_combo output tracking the best combo of the song.
module score_tracker #(
    parameter int W         = 21,
    parameter int NOTE_BITS = 16,
    parameter int DIV_BITS  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           hit_valid,
    output logic           hit_ready,
    input  logic [1:0]     judge,
    input  logic [1:0]     mod,
    input  logic [3:0]     difficulty,
    output logic [W-1:0]   combo,
    output logic [W-1:0]   base_score,
    output logic [W-1:0]   bonus_score,
    output logic [W-1:0]   acc,
    output logic [2:0]     level,
`ifdef SCORE_TRACKER_MAX_COMBO_EN
    output logic [W-1:0]   max_combo,
`endif
    output logic           stats_valid
);

    localparam int EW = NOTE_BITS + 3;
    localparam int CW = $clog2(DIV_BITS + 1);
    localparam logic [W-1:0] W_MAX = '1;

    typedef enum logic [1:0] {IDLE, UPDATE, DIVIDE, GRADE} state_t;

    state_t                state;
    logic [1:0]            judge_q;
    logic [1:0]            mod_q;
    logic [3:0]            diff_q;
    logic [NOTE_BITS-1:0]  notes;
    logic [EW-1:0]         earned;
    logic [DIV_BITS-1:0]   div_q;
    logic [EW-1:0]         div_rem;
    logic [EW-1:0]         div_divisor;
    logic [CW-1:0]         div_count;

    logic [8:0]            weight;
    logic [2:0]            units;
    logic [4:0]            mult;
    logic                  hit;
    logic [12:0]           base_inc;
    logic [W:0]            base_sum;
    logic [W-1:0]          base_next;
    logic [W-1:0]          combo_next;
    logic [W:0]            bonus_inc;
    logic [W+1:0]          bonus_sum;
    logic [W-1:0]          bonus_next;
    logic [NOTE_BITS-1:0]  notes_next;
    logic [EW:0]           earned_sum;
    logic [EW-1:0]         earned_next;
    logic [DIV_BITS-1:0]   dividend;
    logic [EW-1:0]         divisor;
    logic [EW:0]           trial;
    logic [EW-1:0]         trial_diff;
    logic                  trial_ge;
    logic [W-1:0]          acc_next;
    logic [2:0]            level_next;

    assign hit_ready = (state == IDLE) && !clear;

    // Next-value arithmetic for the update step; every accumulator saturates instead of wrapping.
    always_comb begin
        weight = 9'd0;
        units  = 3'd0;
        case (judge_q)
            2'd3: begin weight = 9'd300; units = 3'd6; end
            2'd2: begin weight = 9'd100; units = 3'd2; end
            2'd1: begin weight = 9'd50;  units = 3'd1; end
            default: begin weight = 9'd0; units = 3'd0; end
        endcase
        hit       = judge_q[1];
        mult      = {1'b0, diff_q} + 5'd1;
        base_inc  = 13'(weight) * 13'(mult);
        base_sum  = (W+1)'(base_score) + (W+1)'(base_inc);
        base_next = base_sum[W] ? W_MAX : base_sum[W-1:0];

        combo_next = '0;
        if (hit)
            combo_next = (combo == W_MAX) ? combo : combo + W'(1);

        case (mod_q)
            2'd1:    bonus_inc = {combo_next, 1'b0};
            2'd2:    bonus_inc = (W+1)'(combo_next >> 1);
            default: bonus_inc = (W+1)'(combo_next);
        endcase
        bonus_sum  = (W+2)'(bonus_score) + (W+2)'(bonus_inc);
        bonus_next = bonus_score;
        if (hit)
            bonus_next = (bonus_sum[W+1:W] != 2'd0) ? W_MAX : bonus_sum[W-1:0];

        notes_next  = (&notes) ? notes : notes + NOTE_BITS'(1);
        earned_sum  = (EW+1)'(earned) + (EW+1)'(units);
        earned_next = earned_sum[EW] ? {EW{1'b1}} : earned_sum[EW-1:0];
        dividend    = DIV_BITS'(earned_next) * DIV_BITS'(10000);
        divisor     = EW'(notes_next) * EW'(6);

        // Remainder stays below the divisor, so the difference always fits EW bits.
        trial      = {div_rem, div_q[DIV_BITS-1]};
        trial_ge   = trial >= {1'b0, div_divisor};
        trial_diff = trial[EW-1:0] - div_divisor;

        acc_next = (div_q > DIV_BITS'(10000)) ? W'(10000) : W'(div_q);
        if (acc_next == W'(10000))
            level_next = 3'd6;
        else if (acc_next >= W'(9500))
            level_next = 3'd5;
        else if (acc_next >= W'(9000))
            level_next = 3'd4;
        else if (acc_next >= W'(8000))
            level_next = 3'd3;
        else if (acc_next >= W'(7000))
            level_next = 3'd2;
        else
            level_next = 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= IDLE;
            judge_q     <= '0;
            mod_q       <= '0;
            diff_q      <= '0;
            notes       <= '0;
            earned      <= '0;
            div_q       <= '0;
            div_rem     <= '0;
            div_divisor <= '0;
            div_count   <= '0;
            combo       <= '0;
            base_score  <= '0;
            bonus_score <= '0;
            acc         <= '0;
            level       <= '0;
            stats_valid <= 1'b0;
`ifdef SCORE_TRACKER_MAX_COMBO_EN
            max_combo   <= '0;
`endif
        end else begin
            stats_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit_valid) begin
                        judge_q <= judge;
                        mod_q   <= mod;
                        diff_q  <= difficulty;
                        state   <= UPDATE;
                    end
                end
                UPDATE: begin
                    combo       <= combo_next;
                    base_score  <= base_next;
                    bonus_score <= bonus_next;
                    notes       <= notes_next;
                    earned      <= earned_next;
`ifdef SCORE_TRACKER_MAX_COMBO_EN
                    if (combo_next > max_combo)
                        max_combo <= combo_next;
`endif
                    div_q       <= dividend;
                    div_rem     <= '0;
                    div_divisor <= divisor;
                    div_count   <= '0;
                    state       <= DIVIDE;
                end
                DIVIDE: begin
                    // The dividend shifts out of div_q's top while quotient bits shift in at the bottom.
                    if (trial_ge) begin
                        div_rem <= trial_diff;
                        div_q   <= {div_q[DIV_BITS-2:0], 1'b1};
                    end else begin
                        div_rem <= trial[EW-1:0];
                        div_q   <= {div_q[DIV_BITS-2:0], 1'b0};
                    end
                    div_count <= div_count + CW'(1);
                    if (div_count == CW'(DIV_BITS - 1))
                        state <= GRADE;
                end
                GRADE: begin
                    acc         <= acc_next;
                    level       <= level_next;
                    stats_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
Upstream statistics engine that feeds the scoreboard display stage. It accepts one judged-note event per handshake and maintains the running statistics: combo, base score, bonus score, accuracy and grade level. It derives accuracy with a multi-cycle restoring divider, so it is busy for a fixed window after each event. All outputs are registered and drive the scoreboard's combo/base_score/bonus_score/acc/level inputs directly.

Parameters:
W, 21, width of combo/base_score/bonus_score/acc outputs (saturation limit 2^W-1)
NOTE_BITS, 16, width of internal note counter (saturates at 2^NOTE_BITS-1)
DIV_BITS, 32, dividend width; divider runs DIV_BITS iterations

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
clear  input  1  sync pulse: restart statistics for a new song
hit_valid  input  1  judged-note event present
hit_ready  output  1  block can accept an event this cycle
judge  input  2  0 miss, 1 bad, 2 good, 3 perfect
mod  input  2  bonus modifier: 0 x1, 1 x2, 2 >>1, 3 x1
difficulty  input  4  base multiplier is difficulty+1
combo  output  W  current combo
base_score  output  W  accumulated base score
bonus_score  output  W  accumulated bonus score
acc  output  W  accuracy in hundredths of a percent, 0..10000
level  output  3  grade: 0 none, 1 D, 2 C, 3 B, 4 A, 5 S, 6 SS
stats_valid  output  1  one-cycle pulse when acc and level are updated

Behaviour:
- Reset: rst, or clear when rst is low, zeroes all outputs, internal note and earned counters, and divider. stats_valid=0. FSM returns to IDLE. rst has priority over clear.
- hit_ready = (state==IDLE) && !clear. This is combinational.
- An event is accepted on edge E when hit_valid && hit_ready. judge, mod and difficulty are latched at E. Inputs are ignored while not ready, and held events wait for ready.
- FSM states: IDLE, then UPDATE (1 cycle), then DIVIDE (DIV_BITS cycles), then GRADE (1 cycle), then IDLE.
- UPDATE, committed at edge E+1:
  - weight: perfect 300, good 100, bad 50, miss 0.
  - base_score += weight*(difficulty+1).
  - good/perfect: combo += 1.
  - bad/miss: combo = 0.
  - good/perfect: bonus_score += new combo scaled by mod.
  - notes += 1.
  - earned units += 6/2/1/0 for perfect/good/bad/miss.
  - All accumulators saturate at their maximum and never wrap.
  - Divider is loaded with dividend = earned*10000 (DIV_BITS wide) and divisor = 6*notes.
- DIVIDE: one restoring iteration per cycle, edges E+2..E+DIV_BITS+1. Quotient is floored.
- GRADE, committed at edge E+DIV_BITS+2 (E+34 by default):
  - acc = quotient.
  - level from acc: 10000 gives 6; >=9500 gives 5; >=9000 gives 4; >=8000 gives 3; >=7000 gives 2; otherwise 1.
  - stats_valid=1 for exactly that one cycle.
  - hit_ready returns high the following cycle.
- notes==0 never reaches the divider. acc=0 and level=0 until the first accepted event.
- clear during UPDATE/DIVIDE/GRADE aborts the operation. Outputs are zero after the next edge and no stats_valid is issued.
- combo, base_score and bonus_score hold between events. acc and level hold their previous value throughout DIVIDE.

Optional Feature:
SCORE_TRACKER_MAX_COMBO_EN:
- When defined, adds output port max_combo [W-1:0]. It updates at E+1 to max(max_combo, new combo) and is zeroed by rst/clear.
- When undefined, the port and its register are absent, and all other behaviour is identical.

Test Plan:
1. Assert rst for 2 cycles -> all outputs 0, stats_valid=0. hit_ready=1 after release.
2. One perfect, difficulty=0, mod=0 -> at E+1 combo=1, base_score=300, bonus_score=1. At E+34 acc=10000, level=6, with a single stats_valid pulse.
3. From reset, perfect, perfect, good with difficulty=1, mod=1 -> combo=3, base_score=1400, bonus_score=12. Final acc=7777 (140000/18), level=2.
4. Continue scenario 3 with a miss -> combo=0, base_score=1400, bonus_score=12. acc=5833, level=1.
5. Hold hit_valid high across 3 events -> exactly one accept per ready cycle, spaced 35 cycles apart. Assert clear at E+10 -> all outputs 0 at E+11, no stats_valid, hit_ready=1 at E+11.
6. With SCORE_TRACKER_MAX_COMBO_EN defined: perfect x3, miss, perfect -> combo=1, max_combo=3.
